// File: rtl/booth_radix4_multiplier.sv
// Radix-4 Booth sequential multiplier.
// One Booth digit per cycle, fixed latency, valid/ready handshake.
module booth_radix4_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 signed_mode,
  input  logic                 valid_in,
  output logic                 in_ready,
  output logic                 valid_out,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int ITER   = WIDTH / 2 + 1;
  localparam int EXT_W  = WIDTH + 2;
  localparam int ACC_W  = PROD_W + 2;
  localparam int CNT_W  = $clog2(ITER + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    mcand_q;
  logic [EXT_W:0]      mplier_q;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PROD_W-1:0]   product_q;
  logic                valid_q;

  logic [EXT_W-1:0]    a_ext;
  logic [EXT_W-1:0]    b_ext;
  logic [ACC_W-1:0]    a_wide;
  logic [2:0]          trip;
  logic [ACC_W-1:0]    pp;
  logic [ACC_W-1:0]    acc_d;
  logic                last_digit;

  // Widen operands to WIDTH+2 so both modes share one signed Booth recoding
  always_comb begin
    if (signed_mode) begin
      a_ext = {{2{in_a[WIDTH-1]}}, in_a};
      b_ext = {{2{in_b[WIDTH-1]}}, in_b};
    end else begin
      a_ext = {2'b00, in_a};
      b_ext = {2'b00, in_b};
    end
    a_wide = {{(ACC_W-EXT_W){a_ext[EXT_W-1]}}, a_ext};
  end

  // Current digit triplet {b[2i+1], b[2i], b[2i-1]}; bit 0 of the
  // shifted multiplier register carries b[2i-1] (zero for i = 0)
  assign trip = mplier_q[2:0];

  // Booth digit selection; mcand_q already carries the 4^i weight
  always_comb begin
    pp = '0;
    unique case (trip)
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  assign acc_d      = acc_q + pp;
  assign last_digit = (cnt_q == LAST_CNT);

  // Control FSM and datapath registers with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_in) begin
            mcand_q  <= a_wide;
            mplier_q <= {b_ext, 1'b0};
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 2;
          mplier_q <= mplier_q >> 2;
          cnt_q    <= cnt_q + CNT_ONE;
          if (last_digit) begin
            product_q <= acc_d[PROD_W-1:0];
            valid_q   <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign valid_out = valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Scoreboard bench for the radix-4 Booth multiplier.
// Directed corners, backpressure, mid-op reset and random regression.
module tb_booth_radix4_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        signed_mode;
  logic        valid_in;
  logic        in_ready;
  logic        valid_out;
  logic        out_ready;
  logic [31:0] product;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_acc = -100;
  int gap = 0;
  logic [31:0] sb_q[$];

  booth_radix4_multiplier #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_a        (in_a),
    .in_b        (in_b),
    .signed_mode (signed_mode),
    .valid_in    (valid_in),
    .in_ready    (in_ready),
    .valid_out   (valid_out),
    .out_ready   (out_ready),
    .product     (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_mul(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        s
  );
    longint sa;
    longint sb;
    longint p;
    if (s) begin
      sa = {{48{a[15]}}, a};
      sb = {{48{b[15]}}, b};
    end else begin
      sa = {48'd0, a};
      sb = {48'd0, b};
    end
    p = sa * sb;
    return p[31:0];
  endfunction

  task automatic run_op(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        s,
    input logic [31:0] exp_p,
    input int          hold,
    input bit          scramble
  );
    int w;
    logic [31:0] prev;
    logic [31:0] want;
    prev = product;
    in_a = a;
    in_b = b;
    signed_mode = s;
    valid_in = 1'b1;
    out_ready = 1'b0;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    cmp_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    step();
    sb_q.push_back(exp_p);
    gap = cyc - last_acc;
    last_acc = cyc;
    w = 0;
    while (valid_out !== 1'b1 && w < 20) begin
      if (scramble) begin
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        signed_mode = 1'($urandom);
        out_ready = 1'($urandom);
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      if (w == 3) begin
        cmp_cnt++;
        if (product !== prev || in_ready !== 1'b0) begin
          err_cnt++;
          $display("FAIL calc_hold: product=%h in_ready=%b required %h/0",
                   product, in_ready, prev);
        end
      end
      step();
      w++;
    end
    cmp_cnt++;
    if (w != 9) begin
      err_cnt++;
      $display("FAIL latency: got %0d edges required 9", w);
    end
    want = '0;
    cmp_cnt++;
    if (sb_q.size() == 0) begin
      err_cnt++;
      $display("FAIL scoreboard_empty: size=0 required 1");
    end else begin
      want = sb_q.pop_front();
      if (product !== want) begin
        err_cnt++;
        $display("FAIL product a=%h b=%h s=%b: got %h required %h",
                 a, b, s, product, want);
      end
    end
    repeat (hold) begin
      out_ready = 1'b0;
      valid_in = 1'b1;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      signed_mode = 1'($urandom);
      step();
      cmp_cnt++;
      if (valid_out !== 1'b1 || product !== want || in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL backpressure: vo=%b p=%h rdy=%b required 1/%h/0",
                 valid_out, product, in_ready, want);
      end
    end
    out_ready = 1'b1;
    valid_in = 1'b1;
    step();
    cmp_cnt++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1 || product !== want) begin
      err_cnt++;
      $display("FAIL release: vo=%b rdy=%b p=%h required 0/1/%h",
               valid_out, in_ready, product, want);
    end
    out_ready = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;
    signed_mode = 1'b0;
    repeat (3) step();
    cmp_cnt++;
    if (in_ready !== 1'b1 || valid_out !== 1'b0 || product !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_state: rdy=%b vo=%b p=%h required 1/0/0",
               in_ready, valid_out, product);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta[5];
    logic [15:0] tb[5];
    logic        ts[5];
    logic [31:0] te[5];
    ta = '{16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 16'h1234};
    tb = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    ts = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    te = '{32'h00000001, 32'h40000000, 32'hC0008000,
           32'hFFFE0001, 32'h00000000};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], ts[i], te[i], 1, 0);
    end
  endtask

  task automatic test_backpressure();
    run_op(16'h1234, 16'h5678, 1'b0, 32'h06260060, 20, 1);
  endtask

  task automatic test_back_to_back();
    run_op(16'h0003, 16'h0007, 1'b0, 32'h00000015, 0, 0);
    for (int i = 0; i < 2; i++) begin
      run_op(16'hFFFE, 16'h0003, 1'b1, 32'hFFFFFFFA, 0, 0);
      cmp_cnt++;
      if (gap != 11) begin
        err_cnt++;
        $display("FAIL throughput: gap=%0d required 11", gap);
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_a = 16'h7FFF;
    in_b = 16'h1234;
    signed_mode = 1'b1;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (4) step();
    #2;
    reset = 1'b1;
    #1;
    cmp_cnt++;
    if (in_ready !== 1'b1 || valid_out !== 1'b0 || product !== 32'h0) begin
      err_cnt++;
      $display("FAIL async_reset: rdy=%b vo=%b p=%h required 1/0/0",
               in_ready, valid_out, product);
    end
    step();
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      step();
      if (valid_out === 1'b1) seen++;
    end
    cmp_cnt++;
    if (seen != 0) begin
      err_cnt++;
      $display("FAIL discarded_op: valid cycles=%0d required 0", seen);
    end
    run_op(16'd3, 16'd5, 1'b1, 32'd15, 0, 0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom);
      run_op(a, b, s, ref_mul(a, b, s), $urandom_range(0, 3), 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
